// File: rtl/gate_sweep_checker.sv
// Sweeps the four input vectors of a 2-input gate, samples its output after a
// settle window and scores it against EXP_FUNC. Optional mismatch log: GATE_SWEEP_LOG_EN.
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter logic [3:0]  EXP_FUNC      = 4'b1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [1:0] vec_idx
`ifdef GATE_SWEEP_LOG_EN
    ,
    output logic       first_fail_vld,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_got
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;

    logic       mismatch;
    logic       start_acc;
    logic       chk_fail;

    assign mismatch  = (dut_out != EXP_FUNC[vec_q]);
    assign start_acc = (state_q == ST_IDLE) && start;
    assign chk_fail  = (state_q == ST_CHECK) && mismatch;

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        settle_d   = settle_q;
        err_d      = err_q;
        pass_d     = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_APPLY;
                    vec_d      = 2'd0;
                    pass_cnt_d = 8'd0;
                    err_d      = 8'd0;
                    pass_d     = 1'b0;
                end
            end
            ST_APPLY: begin
                settle_d = SETTLE_LOAD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) state_d = ST_CHECK;
                else                  settle_d = settle_q - 4'd1;
            end
            ST_CHECK: begin
                if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = ST_APPLY;
                end else if (pass_cnt_q < PASS_LAST) begin
                    vec_d      = 2'd0;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    state_d    = ST_APPLY;
                end else begin
                    // Verdict uses err_d so the final CHECK's mismatch is included.
                    pass_d  = (err_d == 8'd0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= 2'd0;
            pass_cnt_q <= 8'd0;
            settle_q   <= 4'd0;
            err_q      <= 8'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
        end
    end

    assign busy    = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done    = (state_q == ST_DONE);
    assign in1     = busy & vec_q[1];
    assign in2     = busy & vec_q[0];
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign vec_idx = vec_q;

`ifdef GATE_SWEEP_LOG_EN
    logic       ff_vld_q;
    logic [1:0] ff_vec_q;
    logic       ff_got_q;

    // Only the first mismatch of a run is kept; later ones are ignored once valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld_q <= 1'b0;
            ff_vec_q <= 2'd0;
            ff_got_q <= 1'b0;
        end else if (start_acc) begin
            ff_vld_q <= 1'b0;
            ff_vec_q <= 2'd0;
            ff_got_q <= 1'b0;
        end else if (chk_fail && !ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_vec_q <= vec_q;
            ff_got_q <= dut_out;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_got = ff_got_q;
`else
    logic unused_log;
    assign unused_log = start_acc ^ chk_fail;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized bench for gate_sweep_checker: four parameterisations, each driven by a
// truth-table gate model, scored against a cycle-timeline model of the sweep.
module tb_gate_sweep_checker;

    localparam int N = 4;
    localparam int S_TAB [N] = '{2, 2, 1, 5};
    localparam int P_TAB [N] = '{1, 3, 100, 2};
    localparam logic [3:0] EXP_OR = 4'b1110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [N-1:0] start;
    logic [N-1:0] dut_out;
    logic [N-1:0] in1, in2, busy, done, pass;
    logic [7:0] err_cnt [N];
    logic [1:0] vec_idx [N];
    logic [3:0] tt [N];
`ifdef GATE_SWEEP_LOG_EN
    logic [N-1:0] ff_vld, ff_got;
    logic [1:0]   ff_vec [N];
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign dut_out[g] = tt[g][{in1[g], in2[g]}];
        gate_sweep_checker #(
            .SETTLE_CYCLES(S_TAB[g]),
            .PASSES       (P_TAB[g]),
            .EXP_FUNC     (EXP_OR)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start[g]),
            .dut_out(dut_out[g]),
            .in1    (in1[g]),
            .in2    (in2[g]),
            .busy   (busy[g]),
            .done   (done[g]),
            .pass   (pass[g]),
            .err_cnt(err_cnt[g]),
            .vec_idx(vec_idx[g])
`ifdef GATE_SWEEP_LOG_EN
            ,
            .first_fail_vld(ff_vld[g]),
            .first_fail_vec(ff_vec[g]),
            .first_fail_got(ff_got[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Mismatches scored after j completed CHECKs, saturated to 8 bits.
    function automatic int exp_err(input logic [3:0] f, input int j);
        int per_pass = 0;
        int part = 0;
        for (int v = 0; v < 4; v++) begin
            if (f[v] != EXP_OR[v]) begin
                per_pass++;
                if (v < j % 4) part++;
            end
        end
        return ((j / 4) * per_pass + part > 255) ? 255 : (j / 4) * per_pass + part;
    endfunction

    task automatic check_idle_zero(input int k, input string tag);
        check({tag, "_busy"}, 32'(busy[k]), 0);
        check({tag, "_done"}, 32'(done[k]), 0);
        check({tag, "_pass"}, 32'(pass[k]), 0);
        check({tag, "_err"},  32'(err_cnt[k]), 0);
        check({tag, "_vec"},  32'(vec_idx[k]), 0);
        check({tag, "_in1"},  32'(in1[k]), 0);
        check({tag, "_in2"},  32'(in2[k]), 0);
    endtask

    // abort_at = 0 runs to completion; otherwise rst_n drops mid-cycle in that run cycle.
    task automatic run_sweep(input int k, input logic [3:0] f, input bit retrig, input int abort_at);
        int per   = S_TAB[k] + 2;
        int len   = 4 * P_TAB[k] * per;
        int total = exp_err(f, 4 * P_TAB[k]);
        int first = -1;
        int j, v;
        for (int i = 3; i >= 0; i--) if (f[i] != EXP_OR[i]) first = i;
        tt[k] = f;
        @(negedge clk);
        start[k] = 1'b1;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            j = (c - 1) / per;
            v = j % 4;
            check("run_busy", 32'(busy[k]), 1);
            check("run_done", 32'(done[k]), 0);
            check("run_pass", 32'(pass[k]), 0);
            check("run_vec",  32'(vec_idx[k]), 32'(v));
            check("run_in1",  32'(in1[k]), 32'(v[1]));
            check("run_in2",  32'(in2[k]), 32'(v[0]));
            check("run_err",  32'(err_cnt[k]), 32'(exp_err(f, j)));
`ifdef GATE_SWEEP_LOG_EN
            if (c == 1) check("log_clr", 32'(ff_vld[k]), 0);
`endif
            if (c == abort_at) begin
                start[k] = 1'b0;
                #1 rst_n = 1'b0;
                #1 check_idle_zero(k, "abort");
                repeat (3) begin
                    @(negedge clk);
                    check("abort_nodone", 32'(done[k]), 0);
                    check("abort_busy",   32'(busy[k]), 0);
                end
                rst_n = 1'b1;
                return;
            end
            start[k] = (c < len) ? 1'($urandom % 2) : 1'b0;
        end
        @(negedge clk);
        check("done_pulse", 32'(done[k]), 1);
        check("done_busy",  32'(busy[k]), 0);
        check("done_in1",   32'(in1[k]), 0);
        check("done_in2",   32'(in2[k]), 0);
        check("done_err",   32'(err_cnt[k]), 32'(total));
        check("done_pass",  32'(pass[k]), 32'(total == 0));
`ifdef GATE_SWEEP_LOG_EN
        check("log_vld", 32'(ff_vld[k]), 32'(total != 0));
        if (first >= 0) begin
            check("log_vec", 32'(ff_vec[k]), 32'(first));
            check("log_got", 32'(ff_got[k]), 32'(f[first]));
        end
`endif
        start[k] = retrig;
        @(negedge clk);
        check("idle_done", 32'(done[k]), 0);
        check("idle_busy", 32'(busy[k]), 0);
        check("idle_pass", 32'(pass[k]), 32'(total == 0));
        check("idle_err",  32'(err_cnt[k]), 32'(total));
        if (retrig) begin
            @(negedge clk);
            start[k] = 1'b0;
            check("retrig_busy", 32'(busy[k]), 1);
            check("retrig_err",  32'(err_cnt[k]), 0);
            check("retrig_pass", 32'(pass[k]), 0);
            check("retrig_vec",  32'(vec_idx[k]), 0);
            repeat (len) @(negedge clk);
            check("retrig_done", 32'(done[k]), 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < N; i++) tt[i] = EXP_OR;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) check_idle_zero(i, "reset");
        rst_n = 1'b1;

        run_sweep(0, 4'b1110, 1'b0, 0);                     // OR gate: clean run
        run_sweep(0, 4'b0000, 1'b0, 0);                     // stuck-at-0
        run_sweep(1, 4'b1000, 1'b0, 0);                     // AND vs OR, 3 passes
        run_sweep(2, 4'b0001, 1'b0, 0);                     // NOR, saturation
        run_sweep(0, 4'b1110, 1'b0, 2 * (S_TAB[0] + 2) + 2); // reset in SETTLE of vec 2
        run_sweep(0, 4'b1110, 1'b0, 0);                     // recovers after abort
        run_sweep(3, 4'(($urandom)), 1'b1, 0);              // start held: retrigger

        repeat (8) begin
            k = int'($urandom_range(0, N - 1));
            if (k == 2 && ($urandom % 2) == 1) k = 1;
            if (($urandom % 4) == 0)
                run_sweep(k, 4'($urandom), 1'b0,
                          2 * (S_TAB[k] + 2) + 2 + int'($urandom_range(0, S_TAB[k] - 1)));
            else
                run_sweep(k, 4'($urandom), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
